// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the single-cycle RV32I core: datapath width, the
// default reset PC, the control-flow opcodes the fetch stage and the
// controller agree on, and the fetch run/halt state encoding.
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 32'h0000_0000;

    // RV32I major opcodes that change control flow
    localparam logic [6:0] OP_JAL    = 7'b110_1111;
    localparam logic [6:0] OP_JALR   = 7'b110_0111;
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_SYSTEM = 7'b111_0011;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_rom.sv
// -----------------------------------------------------------------------------
// inst_rom
// Synchronous single-port instruction ROM, one 32-bit word per address.
// The data path has no reset: dout shows the word addressed at the previous
// rising clock edge.
//
// Parameters:
//   IMEM_AW   word-address width, depth is 2**IMEM_AW words
//   IMEM_INIT name of the program image consumed by the FPGA memory flow
// Ports:
//   clk   in   rising-edge clock
//   addr  in   word address
//   dout  out  registered read data
// -----------------------------------------------------------------------------
module inst_rom
    import core_pkg::*;
#(
    parameter int    IMEM_AW   = 14,
    parameter string IMEM_INIT = "prgmip32.coe"
) (
    input  logic               clk,
    input  logic [IMEM_AW-1:0] addr,
    output logic [XLEN-1:0]    dout
);

    localparam int DEPTH = 1 << IMEM_AW;

    // Words not covered by a named program image read as ebreak so a runaway
    // fetch stops the core instead of executing garbage; with no image named
    // the array is blank.
    localparam logic [XLEN-1:0] FILL_WORD = (IMEM_INIT == "") ? 32'h0000_0000
                                                              : 32'h0010_0073;

    logic [XLEN-1:0] mem [DEPTH] = '{default: FILL_WORD};

    logic [XLEN-1:0] dout_d;
    logic [XLEN-1:0] dout_q;

    always_comb begin
        dout_d = mem[addr];
    end

    always_ff @(posedge clk) begin
        dout_q <= dout_d;
    end

    assign dout = dout_q;

endmodule

// File: rtl/ifetch_unit.sv
// -----------------------------------------------------------------------------
// ifetch_unit
// Instruction fetch stage of the single-cycle RV32I core. Holds the PC, picks
// the next PC, reads the instruction ROM synchronously with next_pc so inst
// and pc change on the same edge, and runs a BOOT/RUN/HALT state machine that
// stops on ebreak and restarts on a rising edge of the resume button.
//
// Build option: define IFETCH_RETIRE_CNT_EN to get a live retired-instruction
// counter on retire_count; otherwise that port is tied to zero.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   branch_taken   conditional branch resolved taken
//   jal, jr        jal/jalr in flight; jr marks jalr
//   imm32          sign-extended immediate of the current instruction
//   rs1_data       rs1 value, jalr base
//   ebreak         current instruction is ebreak
//   stall          hold pc and inst this cycle
//   resume         asynchronous button, releases HALT on a rising edge
//   inst, pc       current instruction word and its address
//   pc_plus4       link address
//   inst_valid     inst is architecturally valid (state RUN)
//   halted         state HALT
//   misalign       sticky: a redirect target had bit1 set
//   retire_count   retired instruction count
// -----------------------------------------------------------------------------
module ifetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
    parameter int          IMEM_AW   = 14,
    parameter string       IMEM_INIT = "prgmip32.coe"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_taken,
    input  logic        jal,
    input  logic        jr,
    input  logic [31:0] imm32,
    input  logic [31:0] rs1_data,
    input  logic        ebreak,
    input  logic        stall,
    input  logic        resume,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        inst_valid,
    output logic        halted,
    output logic        misalign,
    output logic [31:0] retire_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;          // pc_d is next_pc
    logic         misalign_q, misalign_d;
    // [0] first sync stage, [1] second sync stage, [2] previous [1] for edge
    logic [2:0]   res_sync_q, res_sync_d;

    logic [31:0]  pc_plus4_w;
    logic [31:0]  redirect_target;
    logic         redirect;
    logic         resume_rise;

    assign pc_plus4_w  = pc_q + 32'd4;
    assign resume_rise = res_sync_q[1] & ~res_sync_q[2];

    // jalr outranks jal/branch; jal and branch share the pc-relative target.
    always_comb begin
        redirect        = jal | branch_taken;
        redirect_target = pc_q + imm32;
        if (jal && jr) begin
            redirect_target = (rs1_data + imm32) & ~32'h1;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        res_sync_d = {res_sync_q[1], res_sync_q[0], resume};

        case (state_q)
            BOOT: begin
                // pc already holds PC_RESET, which the ROM is reading now
                state_d = RUN;
            end
            RUN: begin
                if (!stall) begin
                    if (ebreak) begin
                        state_d = HALT;    // pc stays on the ebreak
                    end else if (redirect) begin
                        pc_d = {redirect_target[31:2], 1'b0, redirect_target[0]};
                        if (redirect_target[1]) begin
                            misalign_d = 1'b1;
                        end
                    end else begin
                        pc_d = pc_plus4_w;
                    end
                end
            end
            HALT: begin
                // Only an edge seen while halted counts, so a button already
                // held when the halt was taken must be released and pressed.
                if (!stall && resume_rise) begin
                    state_d = RUN;
                    pc_d    = pc_plus4_w;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= PC_RESET;
            misalign_q <= 1'b0;
            res_sync_q <= 3'b000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            res_sync_q <= res_sync_d;
        end
    end

    inst_rom #(
        .IMEM_AW   (IMEM_AW),
        .IMEM_INIT (IMEM_INIT)
    ) u_rom (
        .clk  (clk),
        .addr (pc_d[IMEM_AW+1:2]),
        .dout (inst)
    );

`ifdef IFETCH_RETIRE_CNT_EN
    logic [31:0] retire_q, retire_d;

    // inst_valid is exactly state RUN, so RUN without stall is a retirement
    always_comb begin
        retire_d = retire_q;
        if (state_q == RUN && !stall) begin
            retire_d = retire_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_q <= 32'd0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_count = retire_q;
`else
    assign retire_count = 32'd0;
`endif

    assign pc         = pc_q;
    assign pc_plus4   = pc_plus4_w;
    assign inst_valid = (state_q == RUN);
    assign halted     = (state_q == HALT);
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// -----------------------------------------------------------------------------
// tb_ifetch_unit
// Directed bench for ifetch_unit. The driver applies one vector per clock at
// the falling edge and queues the hand-computed outputs expected after the
// next rising edge; a clocked monitor pops and compares at posedge+1. Reset
// assertion/release points queue an extra entry that a probe monitor checks
// immediately, between clock edges.
// -----------------------------------------------------------------------------
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_taken, jal, jr, ebreak, stall, resume;
    logic [31:0] imm32, rs1_data;
    logic [31:0] inst, pc, pc_plus4, retire_count;
    logic        inst_valid, halted, misalign;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        chk_inst;
        logic        valid;
        logic        halted;
        logic        misalign;
        logic [31:0] retire;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_retire = 32'd0;
    event        probe_ev;

    ifetch_unit #(
        .PC_RESET (32'h0000_0000),
        .IMEM_AW  (14)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .branch_taken (branch_taken),
        .jal          (jal),
        .jr           (jr),
        .imm32        (imm32),
        .rs1_data     (rs1_data),
        .ebreak       (ebreak),
        .stall        (stall),
        .resume       (resume),
        .inst         (inst),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .inst_valid   (inst_valid),
        .halted       (halted),
        .misalign     (misalign),
        .retire_count (retire_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- ROM image owned by the bench ----------------
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        logic [13:0] w;
        w = addr[15:2];
        if (w == 14'd0) return 32'h0050_0093;
        return 32'hC0DE_0000 | {18'h0, w};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s.%s got %h want %h at %0t", n, f, act, want, $time);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk(e.name, "pc", pc, e.pc);
        chk(e.name, "pc_plus4", pc_plus4, e.pc + 32'd4);
        if (e.chk_inst) chk(e.name, "inst", inst, rom_word(e.pc));
        chk(e.name, "inst_valid", {31'd0, inst_valid}, {31'd0, e.valid});
        chk(e.name, "halted", {31'd0, halted}, {31'd0, e.halted});
        chk(e.name, "misalign", {31'd0, misalign}, {31'd0, e.misalign});
        chk(e.name, "retire_count", retire_count, e.retire);
    endtask

    always @(posedge clk) begin
        #1;
        compare_head();
    end

    initial begin
        forever begin
            @(probe_ev);
            #1;
            compare_head();
        end
    end

    // ---------------- driver ----------------
    function automatic logic [31:0] retire_exp();
`ifdef IFETCH_RETIRE_CNT_EN
        return model_retire;
`else
        return 32'd0;
`endif
    endfunction

    task automatic push(input string nm, input logic [31:0] epc, input logic ci,
                        input logic ev, input logic eh, input logic em);
        exp_t e;
        e.name = nm; e.pc = epc; e.chk_inst = ci;
        e.valid = ev; e.halted = eh; e.misalign = em;
        e.retire = retire_exp();
        exp_q.push_back(e);
    endtask

    task automatic clear_inputs();
        branch_taken = 0; jal = 0; jr = 0; ebreak = 0; stall = 0; resume = 0;
        imm32 = 32'd0; rs1_data = 32'd0;
    endtask

    task automatic step(input string nm, input logic st, input logic bt, input logic jl,
                        input logic jx, input logic eb, input logic rs,
                        input logic [31:0] imm, input logic [31:0] rs1,
                        input logic [31:0] epc, input logic ev, input logic eh,
                        input logic em, input logic ret);
        @(negedge clk);
        stall = st; branch_taken = bt; jal = jl; jr = jx; ebreak = eb; resume = rs;
        imm32 = imm; rs1_data = rs1;
        if (ret) model_retire = model_retire + 32'd1;
        push(nm, epc, 1'b1, ev, eh, em);
    endtask

    // Assert reset between clock edges and check the outputs before any edge.
    task automatic async_reset(input string nm);
        @(negedge clk);
        #2 rst = 1'b1;
        model_retire = 32'd0;
        push(nm, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        -> probe_ev;
        @(negedge clk);
    endtask

    // Release reset: BOOT is visible at once, RUN with ROM[0] after one edge.
    task automatic release_reset(input string nm);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        #2;
        push({nm, "_boot"}, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        -> probe_ev;
        push({nm, "_exit"}, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        clear_inputs();
        #1;
        for (int i = 0; i < (1 << 14); i++) begin
            dut.u_rom.mem[i] = rom_word(32'(i) << 2);
        end

        @(negedge clk);
        #2;
        push("reset_values", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        -> probe_ev;

        release_reset("boot1");
        step("seq4",             0,0,0,0,0,0, 32'h0,        32'h0,   32'h4,       1,0,0, 1);
        step("seq8",             0,0,0,0,0,0, 32'h0,        32'h0,   32'h8,       1,0,0, 1);
        for (int i = 0; i < 5; i++)
            step("stall_hold",   1,1,0,0,0,0, 32'h100,      32'h0,   32'h8,       1,0,0, 0);
        step("stall_release_br", 0,1,0,0,0,0, 32'h100,      32'h0,   32'h108,     1,0,0, 1);
        step("br_back_wrap",     0,1,0,0,0,0, 32'hFFFF_FF08,32'h0,   32'h10,      1,0,0, 1);
        step("jal_over_branch",  0,1,1,0,0,0, 32'h20,       32'h0,   32'h30,      1,0,0, 1);
        step("jalr_aligned",     0,1,1,1,0,0, 32'h4,        32'h101, 32'h104,     1,0,0, 1);
        step("jalr_misalign",    0,0,1,1,0,0, 32'h4,        32'h103, 32'h104,     1,0,1, 1);
        step("seq_sticky",       0,0,0,0,0,0, 32'h0,        32'h0,   32'h108,     1,0,1, 1);
        step("jal_rom_wrap",     0,0,1,0,0,0, 32'h0000_FEF8,32'h0,   32'h0001_0000,1,0,1, 1);
        step("jal_to_40",        0,0,1,0,0,1, 32'hFFFF_0040,32'h0,   32'h40,      1,0,1, 1);
        for (int i = 0; i < 2; i++)
            step("stall_ebreak", 1,0,0,0,1,1, 32'h0,        32'h0,   32'h40,      1,0,1, 0);
        step("ebreak_halt",      0,0,0,0,1,1, 32'h0,        32'h0,   32'h40,      0,1,1, 1);
        for (int i = 0; i < 100; i++)
            step("halt_resume_held", 0,0,0,0,1,1, 32'h0,    32'h0,   32'h40,      0,1,1, 0);
        for (int i = 0; i < 5; i++)
            step("halt_resume_low",  0,0,0,0,1,0, 32'h0,    32'h0,   32'h40,      0,1,1, 0);
        step("resume_sync1",     0,0,0,0,0,1, 32'h0,        32'h0,   32'h40,      0,1,1, 0);
        step("resume_sync2",     0,0,0,0,0,0, 32'h0,        32'h0,   32'h40,      0,1,1, 0);
        step("resume_run",       0,0,0,0,0,0, 32'h0,        32'h0,   32'h44,      1,0,1, 0);
        step("post_resume",      0,0,0,0,0,0, 32'h0,        32'h0,   32'h48,      1,0,1, 1);
        for (int i = 0; i < 2; i++)
            step("stall_pre_rst",1,1,0,0,0,0, 32'h8,        32'h0,   32'h48,      1,0,1, 0);

        async_reset("rst_mid_stall");
        release_reset("boot2");
        step("seq4_2",           0,0,0,0,0,0, 32'h0,        32'h0,   32'h4,       1,0,0, 1);
        step("ebreak2",          0,0,0,0,1,0, 32'h0,        32'h0,   32'h4,       0,1,0, 1);
        for (int i = 0; i < 3; i++)
            step("halt2",        0,0,0,0,1,0, 32'h0,        32'h0,   32'h4,       0,1,0, 0);

        async_reset("rst_in_halt");
        release_reset("boot3");
        step("seq4_3",           0,0,0,0,0,0, 32'h0,        32'h0,   32'h4,       1,0,0, 1);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
